// File: rtl/pattern_serializer_pkg.sv
// Shared state encoding, default width and length clamp for pattern_serializer.
package pattern_serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // A length of 0, or one longer than the register, means a full-width pattern.
  function automatic int clamp_len(input int len, input int width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable down-counter for pattern_serializer; flags the final bit (count == 1).
module ser_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             is_last_o
);

  logic [CNT_W-1:0] cnt_q;

  // Holds at 1 rather than reaching 0; the owner reloads before the next pass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && cnt_q > CNT_W'(1)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign is_last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial pattern source for the sequence detector's w input.
// Optional continuous replay of the loaded pattern with PATTERN_SERIALIZER_REPEAT_EN.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] length,
  input  logic             step,
`ifdef PATTERN_SERIALIZER_REPEAT_EN
  input  logic             repeat_en,
`endif
  output logic             ready,
  output logic             w_out,
  output logic             w_valid,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic             ready_q;
  logic             done_q;

  logic [CNT_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;
  logic             load_ok;
  logic             is_last;
  logic             last_step;
  logic             repeat_go;
  logic [WIDTH-1:0] reload_pat;
  logic [CNT_W-1:0] reload_len;

  assign eff_len   = CNT_W'(clamp_len(int'(length), WIDTH));
  assign aligned   = pattern << (WIDTH - int'(eff_len));
  assign load_ok   = ready_q && load;
  assign last_step = (state_q == S_SHIFT) && step && is_last;

`ifdef PATTERN_SERIALIZER_REPEAT_EN
  logic [WIDTH-1:0] pat_sav_q;
  logic [CNT_W-1:0] len_sav_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_sav_q <= '0;
      len_sav_q <= '0;
    end else if (load_ok) begin
      pat_sav_q <= aligned;
      len_sav_q <= eff_len;
    end
  end

  assign repeat_go  = repeat_en;
  assign reload_pat = pat_sav_q;
  assign reload_len = len_sav_q;
`else
  assign repeat_go  = 1'b0;
  assign reload_pat = '0;
  assign reload_len = '0;
`endif

  ser_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (load_ok || (last_step && repeat_go)),
    .load_val_i (load_ok ? eff_len : reload_len),
    .en_i       ((state_q == S_SHIFT) && step),
    .is_last_o  (is_last)
  );

  // ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (load_ok) begin
            sh_q    <= aligned;
            ready_q <= 1'b0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (step) begin
            if (is_last) begin
              done_q <= 1'b1;
              if (repeat_go) begin
                sh_q <= reload_pat;
              end else begin
                sh_q    <= '0;
                ready_q <= 1'b1;
                state_q <= S_IDLE;
              end
            end else begin
              sh_q <= sh_q << 1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready   = ready_q;
  assign w_out   = sh_q[WIDTH-1];
  assign w_valid = (state_q == S_SHIFT);
  assign done    = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: expected bits queued at load, popped per w_valid cycle.
module tb_pattern_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] pattern;
  logic [3:0] length;
  logic       step;
  logic       ready, w_out, w_valid, done;
`ifdef PATTERN_SERIALIZER_REPEAT_EN
  logic       repeat_en = 1'b0;
`endif

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  bit   rep_mode = 1'b0;
  logic exp_q[$];

  pattern_serializer #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .pattern   (pattern),
    .length    (length),
    .step      (step),
`ifdef PATTERN_SERIALIZER_REPEAT_EN
    .repeat_en (repeat_en),
`endif
    .ready     (ready),
    .w_out     (w_out),
    .w_valid   (w_valid),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Queue the active field MSB-first, each bit repeated 'hold' cycles, then issue the load.
  task automatic do_load(input logic [7:0] pat, input logic [3:0] len, input int hold);
    int n;
    n = (len == 0 || len > 8) ? 8 : int'(len);
    for (int i = n - 1; i >= 0; i--)
      for (int h = 0; h < hold; h++) exp_q.push_back(pat[i]);
    pattern = pat;
    length  = len;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic wait_done(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (w_valid) begin
        if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
        else chk("bit", w_out, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (!rep_mode) chk("done_cycle_ready_valid", {ready, w_valid}, 2'b10);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load = 1'b1; pattern = 8'h55; length = 4'd4; step = 1'b0;
    repeat (3) tick();
    chk("rst_ready", ready, 0);
    chk("rst_valid", w_valid, 0);
    reset = 1'b0; load = 1'b0;
    tick();
    chk("post_rst_ready", ready, 1);
    chk("post_rst_wout", w_out, 0);
    chk("post_rst_valid", w_valid, 0);
    chk("post_rst_done", done, 0);

    // 4-bit pattern, step held high
    step = 1'b1;
    do_load(8'b0000_1011, 4'd4, 1);
    chk("first_bit_latency", {w_valid, w_out}, 2'b11);
    exp_done++;
    wait_done(10);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_step_no_effect", {ready, w_valid}, 2'b10);
    chk("q_empty_t1", exp_q.size(), 0);

    // length 0 means full width; step toggling holds each bit 2 cycles
    step = 1'b0;
    do_load(8'hA5, 4'd0, 2);
    exp_done++;
    for (int k = 0; k < 40 && !done; k++) begin
      step = k[0];
      tick();
    end
    chk("toggle_done", done, 1);
    step = 1'b0;
    chk("q_empty_t2", exp_q.size(), 0);

    // length above WIDTH clamps to WIDTH
    step = 1'b1;
    do_load(8'h3C, 4'd12, 1);
    exp_done++;
    wait_done(12);
    chk("q_empty_t3", exp_q.size(), 0);

    // load during SHIFT ignored, then reset after the third bit
    tick();
    do_load(8'h00, 4'd8, 1);
    pattern = 8'hFF; load = 1'b1;
    tick();
    tick();
    @(negedge clock);
    #1;
    reset = 1'b1; load = 1'b0; step = 1'b0;
    #1;
    chk("abort_valid", w_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", ready, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("abort_ready_after", ready, 1);
    chk("abort_bits_left", exp_q.size(), 5);
    exp_q.delete();
    chk("abort_no_done", done_cnt, exp_done);

    // back-to-back: load in the done cycle
    step = 1'b1;
    do_load(8'b0000_1011, 4'd4, 1);
    exp_done++;
    wait_done(10);
    do_load(8'b0000_0110, 4'd3, 1);
    chk("b2b_first_bit", {w_valid, w_out}, 2'b11);
    exp_done++;
    wait_done(10);
    chk("q_empty_t5", exp_q.size(), 0);

`ifdef PATTERN_SERIALIZER_REPEAT_EN
    tick();
    rep_mode = 1'b1;
    repeat_en = 1'b1;
    for (int i = 2; i >= 0; i--) exp_q.push_back(i != 0);
    do_load(8'b0000_0110, 4'd3, 1);
    exp_done += 2;
    wait_done(10);
    chk("rep_ready_low", ready, 0);
    chk("rep_no_bubble", {w_valid, w_out}, 2'b11);
    repeat_en = 1'b0;
    wait_done(10);
    chk("rep_end_idle", {ready, w_valid}, 2'b10);
    rep_mode = 1'b0;
    chk("q_empty_rep", exp_q.size(), 0);
`endif

    step = 1'b0;
    tick();
    tick();
    chk("done_total", done_cnt, exp_done);
    chk("q_empty_final", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
